pulse_stretcher: RTL

Converts single-cycle strobes, such as the edge pulses our edge detector produces, back into level windows. Each accepted strobe drives level_out high for a programmable number of clock cycles. Two modes are supported:
- retrigger: a strobe extends the current window.
- queue: strobes arriving during a window are counted and replayed as separate windows, each separated by a low gap.
The block sits downstream of edge detection and drives LED/enable-style consumers that need a sustained level.

---
 rtl/pulse_stretcher_pkg.sv | 18 +
 rtl/sat_counter.sv | 36 +++
 rtl/pulse_stretcher.sv | 136 +++++++++++++
 3 files changed

// File: rtl/pulse_stretcher_pkg.sv
// Shared types and default parameters for the pulse stretcher.
package pulse_stretcher_pkg;

  // Controller states; level_out is high only in S_HIGH.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HIGH = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  localparam int DEF_CNT_W  = 8;
  localparam int DEF_PEND_W = 3;
  localparam int DEF_GAP    = 1;

  // Gap lengths run 1..255, so an 8-bit gap counter always suffices.
  localparam int GAP_CNT_W  = 8;

endpackage

// File: rtl/sat_counter.sv
// Saturating up/down counter holding the number of queued strobes.
// A simultaneous increment and decrement cancel out. The count never
// wraps in either direction.
module sat_counter #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_inc,
  input  logic         i_dec,
  output logic [W-1:0] o_value,
  output logic         o_at_max
);

  logic [W-1:0] r_value;
  logic         w_at_max;
  logic         w_at_zero;

  assign w_at_max  = (r_value == {W{1'b1}});
  assign w_at_zero = (r_value == '0);

  // Count up or down; hold at both limits and when inc and dec cancel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_value <= '0;
    end else if (i_inc && !i_dec && !w_at_max) begin
      r_value <= r_value + 1'b1;
    end else if (i_dec && !i_inc && !w_at_zero) begin
      r_value <= r_value - 1'b1;
    end
  end

  assign o_value  = r_value;
  assign o_at_max = w_at_max;

endmodule

// File: rtl/pulse_stretcher.sv
// Stretches single-cycle strobes into level windows of programmable
// length. In retrigger mode a strobe during a window extends it. In
// queue mode strobes are counted and replayed as separate windows,
// with GAP low cycles between them.
//
// Handshake: there is none. pulse_in is a plain strobe; every cycle it
// is high counts as one event and is either acted on, queued, or
// dropped with a one-cycle overflow indication. No back-pressure.
module pulse_stretcher
  import pulse_stretcher_pkg::*;
#(
  parameter int CNT_W  = DEF_CNT_W,
  parameter int PEND_W = DEF_PEND_W,
  parameter int GAP    = DEF_GAP
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pulse_in,
  input  logic [CNT_W-1:0]  width,
  input  logic              retrigger,
  output logic              level_out,
  output logic [PEND_W-1:0] pending,
  output logic              overflow,
  output logic              busy
);

  localparam logic [GAP_CNT_W-1:0] GAP_LOAD = GAP_CNT_W'(GAP);

  state_t               r_state;
  logic [CNT_W-1:0]     r_win_cnt;
  logic [GAP_CNT_W-1:0] r_gap_cnt;
  logic                 r_level;

  logic [CNT_W-1:0]     w_win_len;
  logic                 w_in_high;
  logic                 w_in_gap;
  logic                 w_last_high;
  logic                 w_last_gap;
  logic                 w_has_pend;
  logic                 w_retrig_hit;
  logic                 w_inc;
  logic                 w_dec;
  logic [PEND_W-1:0]    w_pending;
  logic                 w_at_max;

  // A width of zero still produces a one-cycle window.
  assign w_win_len = (width == '0) ? CNT_W'(1) : width;

  assign w_in_high   = (r_state == S_HIGH);
  assign w_in_gap    = (r_state == S_GAP);
  assign w_last_high = w_in_high && (r_win_cnt == CNT_W'(1));
  assign w_last_gap  = w_in_gap && (r_gap_cnt == GAP_CNT_W'(1));
  assign w_has_pend  = (w_pending != '0);

  // A strobe in HIGH with retrigger set reloads the window instead of
  // being queued.
  assign w_retrig_hit = w_in_high && retrigger && pulse_in;

  // Queue a strobe arriving in HIGH (queue mode) or in GAP (either
  // mode). On the last GAP cycle with nothing pending, the strobe starts
  // the next window directly and is not counted; with something
  // pending it is counted and cancels against the replay decrement.
  assign w_inc = pulse_in &&
                 ((w_in_high && !retrigger) ||
                  (w_in_gap && !(w_last_gap && !w_has_pend)));
  assign w_dec = w_last_gap && w_has_pend;

  sat_counter #(
    .W (PEND_W)
  ) u_pend (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_inc    (w_inc),
    .i_dec    (w_dec),
    .o_value  (w_pending),
    .o_at_max (w_at_max)
  );

  // Window/gap controller with a registered level output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_win_cnt <= '0;
      r_gap_cnt <= '0;
      r_level   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (pulse_in) begin
            r_state   <= S_HIGH;
            r_win_cnt <= w_win_len;
            r_level   <= 1'b1;
          end
        end
        S_HIGH: begin
          if (w_retrig_hit) begin
            r_win_cnt <= w_win_len;
          end else if (w_last_high) begin
            r_state   <= S_GAP;
            r_win_cnt <= '0;
            r_gap_cnt <= GAP_LOAD;
            r_level   <= 1'b0;
          end else begin
            r_win_cnt <= r_win_cnt - 1'b1;
          end
        end
        S_GAP: begin
          if (w_last_gap) begin
            r_gap_cnt <= '0;
            if (w_has_pend || pulse_in) begin
              r_state   <= S_HIGH;
              r_win_cnt <= w_win_len;
              r_level   <= 1'b1;
            end else begin
              r_state <= S_IDLE;
            end
          end else begin
            r_gap_cnt <= r_gap_cnt - 1'b1;
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_win_cnt <= '0;
          r_gap_cnt <= '0;
          r_level   <= 1'b0;
        end
      endcase
    end
  end

  assign level_out = r_level;
  assign pending   = w_pending;
  assign overflow  = w_inc && w_at_max && !w_dec;
  assign busy      = (r_state != S_IDLE);

endmodule
